// File: rtl/axi_csr_bank.sv
// axi_csr_bank: AXI4 slave register bank with bursts, strobes and RO masking.
// Define AXI_CSR_BANK_WRAP_EN to accept WRAP bursts of length 2/4/8/16.
module axi_csr_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int ID_W = 5,
   parameter logic [2**(ADDR_W-$clog2(DATA_W/8))-1:0] RO_MASK = '0,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic s_aclk,
   input  logic s_areset,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [ID_W-1:0] s_axi_awid,
   input  logic [7:0] s_axi_awlen,
   input  logic [2:0] s_axi_awsize,
   input  logic [1:0] s_axi_awburst,
   input  logic s_axi_awvalid,
   output logic s_axi_awready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic s_axi_wlast,
   input  logic s_axi_wvalid,
   output logic s_axi_wready,
   output logic [ID_W-1:0] s_axi_bid,
   output logic [1:0] s_axi_bresp,
   output logic s_axi_bvalid,
   input  logic s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [ID_W-1:0] s_axi_arid,
   input  logic [7:0] s_axi_arlen,
   input  logic [2:0] s_axi_arsize,
   input  logic [1:0] s_axi_arburst,
   input  logic s_axi_arvalid,
   output logic s_axi_arready,
   output logic [DATA_W-1:0] s_axi_rdata,
   output logic [ID_W-1:0] s_axi_rid,
   output logic [1:0] s_axi_rresp,
   output logic s_axi_rlast,
   output logic s_axi_rvalid,
   input  logic s_axi_rready,
   output logic [2**(ADDR_W-$clog2(DATA_W/8))*DATA_W-1:0] csr_q,
   output logic [2**(ADDR_W-$clog2(DATA_W/8))-1:0] csr_wr_pulse
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int IDX_W = ADDR_W - OFF_W;
   localparam int NUM_REGS = 2 ** IDX_W;
   localparam int IXW = IDX_W + 9;
   localparam logic [IXW-1:0] LIMIT = IXW'(NUM_REGS);
   localparam logic [2:0] SIZE_OK = 3'(OFF_W);
`ifdef AXI_CSR_BANK_WRAP_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic burst_bad(input logic [1:0] burst,
                                      input logic [7:0] len,
                                      input logic [2:0] size);
      logic len_ok, wrap_bad;
      len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      unique case (burst)
         2'b00, 2'b01: wrap_bad = 1'b0;
         2'b10: wrap_bad = !WRAP_EN || !len_ok;
         default: wrap_bad = 1'b1;
      endcase
      return (size != SIZE_OK) | wrap_bad;
   endfunction

   // WRAP keeps the upper index bits and wraps the low len bits
   function automatic logic [IXW-1:0] next_idx(input logic [IXW-1:0] idx,
                                               input logic [1:0] burst,
                                               input logic [7:0] len);
      logic [IXW-1:0] m;
      m = IXW'(len);
      unique case (burst)
         2'b00: next_idx = idx;
         2'b10: next_idx = (idx & ~m) | ((idx + IXW'(1)) & m);
         default: next_idx = idx + IXW'(1);
      endcase
   endfunction

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   assign csr_q = regs;

   w_state_t w_state;
   logic [IXW-1:0] w_idx;
   logic [7:0] w_len, w_cnt;
   logic [1:0] w_burst;
   logic w_bad, w_err, w_fire, w_oor, w_beat_err;

   assign w_fire = s_axi_wvalid & s_axi_wready;
   assign w_oor = w_idx >= LIMIT;
   assign w_beat_err = w_bad | w_oor | (!w_oor && RO_MASK[w_idx[IDX_W-1:0]]);

   always_ff @(posedge s_aclk or posedge s_areset) begin
      if (s_areset) begin
         w_state <= W_IDLE;
         s_axi_awready <= 1'b1;
         s_axi_wready <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp <= 2'b00;
         s_axi_bid <= '0;
         w_idx <= '0;
         w_len <= '0;
         w_cnt <= '0;
         w_burst <= '0;
         w_bad <= 1'b0;
         w_err <= 1'b0;
      end else begin
         unique case (w_state)
            W_IDLE: if (s_axi_awvalid) begin
               w_state <= W_DATA;
               s_axi_awready <= 1'b0;
               s_axi_wready <= 1'b1;
               w_idx <= IXW'(s_axi_awaddr[ADDR_W-1:OFF_W]);
               w_len <= s_axi_awlen;
               w_burst <= s_axi_awburst;
               w_cnt <= '0;
               w_err <= 1'b0;
               w_bad <= burst_bad(s_axi_awburst, s_axi_awlen, s_axi_awsize);
               s_axi_bid <= s_axi_awid;
            end
            W_DATA: if (w_fire) begin
               w_idx <= next_idx(w_idx, w_burst, w_len);
               w_cnt <= w_cnt + 8'd1;
               w_err <= w_err | w_beat_err;
               if (w_cnt == w_len) begin
                  w_state <= W_RESP;
                  s_axi_wready <= 1'b0;
                  s_axi_bvalid <= 1'b1;
                  s_axi_bresp <= (w_err | w_beat_err | !s_axi_wlast) ? 2'b10 : 2'b00;
               end
            end
            W_RESP: if (s_axi_bready) begin
               w_state <= W_IDLE;
               s_axi_bvalid <= 1'b0;
               s_axi_awready <= 1'b1;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_aclk or posedge s_areset) begin
      if (s_areset) begin
         regs <= {NUM_REGS{RST_VAL}};
         csr_wr_pulse <= '0;
      end else begin
         csr_wr_pulse <= '0;
         if (w_fire && !w_beat_err) begin
            for (int b = 0; b < DATA_W / 8; b++)
               if (s_axi_wstrb[b])
                  regs[w_idx[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            csr_wr_pulse[w_idx[IDX_W-1:0]] <= |s_axi_wstrb;
         end
      end
   end

   r_state_t r_state;
   logic [IXW-1:0] r_idx, ld_idx;
   logic [7:0] r_len, r_cnt;
   logic [1:0] r_burst;
   logic r_bad, ld_bad, ld_err;

   // Index and error of the beat loaded at this edge
   always_comb begin
      ld_idx = next_idx(r_idx, r_burst, r_len);
      ld_bad = r_bad;
      if (r_state == R_IDLE) begin
         ld_idx = IXW'(s_axi_araddr[ADDR_W-1:OFF_W]);
         ld_bad = burst_bad(s_axi_arburst, s_axi_arlen, s_axi_arsize);
      end
      ld_err = ld_bad | (ld_idx >= LIMIT);
   end

   always_ff @(posedge s_aclk or posedge s_areset) begin
      if (s_areset) begin
         r_state <= R_IDLE;
         s_axi_arready <= 1'b1;
         s_axi_rvalid <= 1'b0;
         s_axi_rlast <= 1'b0;
         s_axi_rresp <= 2'b00;
         s_axi_rdata <= '0;
         s_axi_rid <= '0;
         r_idx <= '0;
         r_len <= '0;
         r_cnt <= '0;
         r_burst <= '0;
         r_bad <= 1'b0;
      end else begin
         unique case (r_state)
            R_IDLE: if (s_axi_arvalid) begin
               r_state <= R_DATA;
               s_axi_arready <= 1'b0;
               r_idx <= ld_idx;
               r_len <= s_axi_arlen;
               r_burst <= s_axi_arburst;
               r_bad <= ld_bad;
               r_cnt <= '0;
               s_axi_rid <= s_axi_arid;
               s_axi_rvalid <= 1'b1;
               s_axi_rdata <= ld_err ? '0 : regs[ld_idx[IDX_W-1:0]];
               s_axi_rresp <= ld_err ? 2'b10 : 2'b00;
               s_axi_rlast <= (s_axi_arlen == 8'd0);
            end
            R_DATA: if (s_axi_rready) begin
               if (s_axi_rlast) begin
                  r_state <= R_IDLE;
                  s_axi_rvalid <= 1'b0;
                  s_axi_arready <= 1'b1;
               end else begin
                  r_idx <= ld_idx;
                  r_cnt <= r_cnt + 8'd1;
                  s_axi_rdata <= ld_err ? '0 : regs[ld_idx[IDX_W-1:0]];
                  s_axi_rresp <= ld_err ? 2'b10 : 2'b00;
                  s_axi_rlast <= (r_cnt + 8'd1 == r_len);
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_csr_bank.sv
// tb_axi_csr_bank: directed bench for axi_csr_bank with a spec-level register model.
// Build with AXI_CSR_BANK_WRAP_EN to exercise the WRAP-enabled variant.
module tb_axi_csr_bank;
   localparam logic [7:0] RO = 8'h02;
   localparam logic [31:0] RV = 32'hC0DE_0000;
`ifdef AXI_CSR_BANK_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic clk, s_areset;
   logic [4:0] awaddr, awid, araddr, arid, bid, rid;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0] wstrb;
   logic [255:0] csr_q;
   logic [7:0] csr_wr_pulse;

   axi_csr_bank #(.DATA_W(32), .ADDR_W(5), .ID_W(5), .RO_MASK(RO), .RST_VAL(RV)) dut (
      .s_aclk(clk), .s_areset(s_areset),
      .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awlen(awlen),
      .s_axi_awsize(awsize), .s_axi_awburst(awburst),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arid(arid), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp),
      .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .csr_q(csr_q), .csr_wr_pulse(csr_wr_pulse));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   bit chk_en = 1'b0;
   logic [31:0] model [8];
   logic [7:0] exp_pulse;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      exp_pulse = '0;
   endtask

   function automatic int beat_index(int start, int k, int len, logic [1:0] burst);
      int win, base;
      if (burst == 2'b00) return start;
      if (burst == 2'b10) begin
         win = len + 1;
         base = (start / win) * win;
         return base + (start - base + k) % win;
      end
      return start + k;
   endfunction

   function automatic bit burst_ok(logic [1:0] burst, int len, logic [2:0] size);
      if (size != 3'd2) return 1'b0;
      if (burst == 2'b00 || burst == 2'b01) return 1'b1;
      if (burst == 2'b10)
         return WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15);
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      logic [255:0] e;
      if (chk_en) begin
         for (int i = 0; i < 8; i++) e[i*32 +: 32] = model[i];
         chk("csr_q", csr_q, e);
         chk("wr_pulse", {248'd0, csr_wr_pulse}, {248'd0, exp_pulse});
      end
   end

   task automatic wr_burst(input logic [4:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [4:0] id, input logic [31:0] d0,
                           input logic [31:0] step, input logic [3:0] strb, input bit last_ok);
      int idx;
      bit ok, any_err;
      tick();
      awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awid = id;
      awvalid = 1'b1;
      @(negedge clk) chk("awready", {255'd0, awready}, 256'd1);
      tick();
      awvalid = 1'b0;
      any_err = !last_ok;
      for (int k = 0; k <= len; k++) begin
         idx = beat_index(int'(addr) / 4, k, len, burst);
         ok = burst_ok(burst, len, size) && idx < 8 && !(idx < 8 && RO[idx]);
         wvalid = 1'b1;
         wdata = d0 + 32'(k) * step;
         wstrb = strb;
         wlast = (k == len) ? last_ok : 1'b0;
         @(negedge clk) chk("wready", {255'd0, wready}, 256'd1);
         tick();
         if (ok) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
            if (|strb) exp_pulse[idx] = 1'b1;
         end
         any_err |= !ok;
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
      @(negedge clk);
      chk("bvalid", {255'd0, bvalid}, 256'd1);
      chk("bresp", {254'd0, bresp}, any_err ? 256'd2 : 256'd0);
      chk("bid", {251'd0, bid}, {251'd0, id});
      tick();
      @(negedge clk);
      chk("bvalid_hold", {255'd0, bvalid}, 256'd1);
      chk("bresp_hold", {254'd0, bresp}, any_err ? 256'd2 : 256'd0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      @(negedge clk);
      chk("bvalid_drop", {255'd0, bvalid}, 256'd0);
      chk("awready_back", {255'd0, awready}, 256'd1);
   endtask

   task automatic rd_burst(input logic [4:0] addr, input int len, input logic [1:0] burst,
                           input logic [4:0] id, input bit stall);
      int idx;
      bit ok;
      logic [31:0] ed;
      tick();
      araddr = addr; arlen = 8'(len); arburst = burst; arsize = 3'd2; arid = id;
      arvalid = 1'b1; rready = 1'b1;
      @(negedge clk) chk("arready", {255'd0, arready}, 256'd1);
      tick();
      arvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         idx = beat_index(int'(addr) / 4, k, len, burst);
         ok = burst_ok(burst, len, 3'd2) && idx < 8;
         ed = ok ? model[idx] : 32'd0;
         @(negedge clk);
         chk("rvalid", {255'd0, rvalid}, 256'd1);
         chk("rdata", {224'd0, rdata}, {224'd0, ed});
         chk("rresp", {254'd0, rresp}, ok ? 256'd0 : 256'd2);
         chk("rlast", {255'd0, rlast}, (k == len) ? 256'd1 : 256'd0);
         chk("rid", {251'd0, rid}, {251'd0, id});
         if (stall && k == 0) begin
            rready = 1'b0;
            tick();
            @(negedge clk);
            chk("rvalid_hold", {255'd0, rvalid}, 256'd1);
            chk("rdata_hold", {224'd0, rdata}, {224'd0, ed});
            rready = 1'b1;
         end
         tick();
      end
      rready = 1'b0;
      @(negedge clk);
      chk("rvalid_drop", {255'd0, rvalid}, 256'd0);
      chk("arready_back", {255'd0, arready}, 256'd1);
   endtask

   initial begin
      logic [31:0] old;
      s_areset = 1'b1;
      {awaddr, awid, awlen, awsize, awburst, awvalid} = '0;
      {wdata, wstrb, wlast, wvalid, bready} = '0;
      {araddr, arid, arlen, arsize, arburst, arvalid, rready} = '0;
      for (int i = 0; i < 8; i++) model[i] = RV;
      exp_pulse = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_ready", {254'd0, awready, arready}, 256'd3);
      chk("rst_valid", {252'd0, wready, bvalid, rvalid, rlast}, 256'd0);
      chk("rst_resp", {246'd0, bresp, rresp, bid, rid}, 256'd0);
      chk("rst_rdata", {224'd0, rdata}, 256'd0);
      chk("rst_pulse", {248'd0, csr_wr_pulse}, 256'd0);
      chk("rst_reg7", {224'd0, csr_q[255:224]}, {224'd0, RV});
      tick();
      s_areset = 1'b0;
      chk_en = 1'b1;

      wr_burst(5'h00, 0, 2'b01, 3'd2, 5'd1, 32'hDEADBEEF, 32'd0, 4'hF, 1'b1);
      rd_burst(5'h00, 0, 2'b01, 5'd2, 1'b0);
      chk("lit_reg0", {224'd0, csr_q[31:0]}, {224'd0, 32'hDEADBEEF});

      wr_burst(5'h08, 3, 2'b01, 3'd2, 5'd3, 32'd1, 32'd1, 4'hF, 1'b1);
      rd_burst(5'h08, 3, 2'b01, 5'd4, 1'b1);
      chk("lit_reg5", {224'd0, csr_q[191:160]}, 256'd4);

      wr_burst(5'h18, 0, 2'b01, 3'd2, 5'd5, 32'h11223344, 32'd0, 4'hF, 1'b1);
      wr_burst(5'h18, 0, 2'b01, 3'd2, 5'd6, 32'hAABBCCDD, 32'd0, 4'b0101, 1'b1);
      chk("lit_strobe", {224'd0, csr_q[223:192]}, {224'd0, 32'h11BB33DD});

      wr_burst(5'h04, 0, 2'b01, 3'd2, 5'd7, 32'hFFFFFFFF, 32'd0, 4'hF, 1'b1);
      chk("lit_ro", {224'd0, csr_q[63:32]}, {224'd0, RV});
      rd_burst(5'h10, 7, 2'b01, 5'd8, 1'b0);

      wr_burst(5'h1C, 2, 2'b00, 3'd2, 5'd9, 32'd10, 32'd10, 4'hF, 1'b1);
      chk("lit_fixed", {224'd0, csr_q[255:224]}, 256'd30);
      wr_burst(5'h00, 0, 2'b01, 3'd1, 5'd10, 32'h12345678, 32'd0, 4'hF, 1'b1);
      wr_burst(5'h0C, 1, 2'b01, 3'd2, 5'd11, 32'h55, 32'h11, 4'hF, 1'b0);
      wr_burst(5'h00, 0, 2'b11, 3'd2, 5'd12, 32'h99, 32'd0, 4'hF, 1'b1);
      wr_burst(5'h08, 3, 2'b10, 3'd2, 5'd13, 32'h100, 32'h100, 4'hF, 1'b1);
      rd_burst(5'h08, 3, 2'b10, 5'd14, 1'b0);
      wr_burst(5'h18, 3, 2'b01, 3'd2, 5'd15, 32'hA0, 32'h1, 4'hF, 1'b1);
      chk("lit_edge", {224'd0, csr_q[255:224]}, 256'hA1);

      // write commit and read load of reg 6 on the same edge
      tick();
      awaddr = 5'h18; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awid = 5'd3;
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = 32'h600DF00D; wstrb = 4'hF; wlast = 1'b1;
      araddr = 5'h18; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arid = 5'd9;
      arvalid = 1'b1;
      old = model[6];
      @(negedge clk) chk("same_rdy", {254'd0, wready, arready}, 256'd3);
      tick();
      model[6] = 32'h600DF00D;
      exp_pulse[6] = 1'b1;
      wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      chk("same_rdata", {224'd0, rdata}, {224'd0, old});
      chk("same_valid", {253'd0, rvalid, rlast, bvalid}, 256'd7);
      chk("same_bresp", {254'd0, bresp}, 256'd0);
      tick();
      bready = 1'b0; rready = 1'b0;
      rd_burst(5'h18, 0, 2'b01, 5'd1, 1'b0);

      // reset in the middle of a stalled read burst
      tick();
      araddr = 5'h00; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2; arid = 5'd4;
      arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      @(negedge clk) chk("mid_rvalid", {255'd0, rvalid}, 256'd1);
      tick();
      s_areset = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = RV;
      #1;
      chk("arst_rvalid", {255'd0, rvalid}, 256'd0);
      chk("arst_arready", {255'd0, arready}, 256'd1);
      chk("arst_reg0", {224'd0, csr_q[31:0]}, {224'd0, RV});
      tick();
      s_areset = 1'b0;
      tick();
      @(negedge clk) chk("post_rvalid", {255'd0, rvalid}, 256'd0);
      rd_burst(5'h00, 1, 2'b01, 5'd6, 1'b0);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/axi_csr_bank.md
# axi_csr_bank

Parametrised AXI4 slave control/status register bank, the next generation of the CPU CSR block. Holds NUM_REGS registers of DATA_W bits behind independent AXI4 write and read channels. Supports INCR/FIXED bursts, byte strobes, read-only masking, error responses and per-register write pulses. Sits between the system interconnect and the CPU core control logic.

## Interface
- DATA_W, 32: register and bus data width; 32 or 64 only.
- ADDR_W, 5: AXI byte-address width; NUM_REGS = 2^(ADDR_W - log2(DATA_W/8)).
- ID_W, 5: AXI ID width.
- RO_MASK, 0: NUM_REGS-bit mask; bit i set makes register i read-only.
- RST_VAL, 0: DATA_W reset value for every register.
- s_aclk  in  1  clock; all logic on rising edge.
- s_areset  in  1  reset, asynchronous and active-high.
- s_axi_awaddr/awid/awlen/awsize/awburst  in  ADDR_W/ID_W/8/3/2  write address channel.
- s_axi_awvalid  in  1 ; s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data channel.
- s_axi_wvalid  in  1 ; s_axi_wready  out  1.
- s_axi_bid/bresp  out  ID_W/2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1.
- s_axi_araddr/arid/arlen/arsize/arburst  in  ADDR_W/ID_W/8/3/2  read address channel.
- s_axi_arvalid  in  1 ; s_axi_arready  out  1.
- s_axi_rdata/rid/rresp  out  DATA_W/ID_W/2 ; s_axi_rlast/rvalid  out  1 ; s_axi_rready  in  1.
- csr_q  out  NUM_REGS*DATA_W  current register contents, register i at [i*DATA_W +: DATA_W].
- csr_wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written.

## Operation
- Write FSM: W_IDLE -> (awvalid&awready) W_DATA -> (beat count == awlen accepted) W_RESP -> (bvalid&bready) W_IDLE.
- Read FSM: R_IDLE -> (arvalid&arready) R_DATA -> (rvalid&rready&rlast) R_IDLE. Channels fully independent.
- Register index = addr >> log2(DATA_W/8); low byte-offset bits ignored.
- INCR: index +1 per beat. FIXED: index constant. WRAP and reserved: see Configuration.
- Beat error (SLVERR, 2'b10): index >= NUM_REGS, size != log2(DATA_W/8), unsupported burst, or write to RO register. Errored write beats commit nothing.
- bresp = SLVERR if any beat in the burst errored, else OKAY; bid = captured awid.
- Write beat: bytes with wstrb=1 updated; csr_wr_pulse[i] asserted the cycle after commit if any strobe set and beat not errored.
- Read: rresp per beat; errored beats return rdata=0. rid = captured arid; rlast on beat awlen/arlen.
- wlast ignored for beat counting; wlast mismatch on last beat forces bresp SLVERR.

## Timing
- Reset (asynchronous): all registers = RST_VAL; both FSMs idle; awready=arready=1; wready=bvalid=rvalid=rlast=0; bresp=rresp=0; bid=rid=0; rdata=0; csr_wr_pulse=0.
- awready/arready high only in idle states; wready high only in W_DATA.
- Write commits at the wvalid&wready edge; csr_q reflects it the next cycle.
- bvalid rises the cycle after the last beat; held with bid/bresp stable until bready.
- rvalid rises the cycle after arvalid&arready (1-cycle latency); rdata/rresp/rlast held until rready; next beat the cycle after each handshake (full throughput with rready=1).
- Same-cycle read-beat load and write commit to one register: read returns pre-write value.
- Reset mid-burst: burst abandoned, no response issued.

## Configuration
- AXI_CSR_BANK_WRAP_EN defined: WRAP bursts supported; awlen/arlen must be 1, 3, 7 or 15, index wraps within an aligned (len+1)-register window; other lengths -> SLVERR on every beat.
- Undefined: WRAP treated as unsupported; every beat SLVERR, no writes.

## Test plan
- Write 0xDEADBEEF to addr 0x00, wstrb 4'hF -> bresp OKAY, csr_wr_pulse[0] one cycle, read 0x00 returns 0xDEADBEEF rresp OKAY rlast=1.
- INCR write len=3 at 0x08 data 1,2,3,4 -> regs 2..5 = 1..4, single bresp OKAY; INCR read len=3 returns same with rlast only on 4th beat.
- Strobe 4'b0101 of 0xAABBCCDD over 0x11223344 -> read 0x11BB33DD.
- RO_MASK bit 1 set, write 0xFFFFFFFF to 0x04 -> bresp SLVERR, reg 1 stays RST_VAL, no pulse; INCR read len=7 at 0x10 -> beats at index >= 8 return 0 with SLVERR.
- WRAP len=3 at 0x08 -> indices 2,3,0,1 with AXI_CSR_BANK_WRAP_EN; all SLVERR without it.
- Assert s_areset mid read burst with rready=0 -> rvalid drops immediately, arready=1, registers back to RST_VAL.
